// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD core and its job sequencer.
//   GCD_W         default operand/result width
//   seq_state_e   job sequencer state encoding
//   gcd_result_t  result record {gcd, err}; the core testbench uses it too
package gcd_pkg;

  localparam int GCD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [GCD_W-1:0] gcd;
    logic             err;
  } gcd_result_t;

endpackage

// File: rtl/gcd_timeout_ctr.sv
// Go-to-done watchdog for the GCD job sequencer.
//   clk, rst  clock, synchronous active-high reset
//   clear     forces the count to zero (used whenever no job is in flight)
//   enable    counts one cycle (asserted from the go cycle onward)
//   hit       asserted in the cycle that is the TIMEOUT-th cycle since go
// The count holds the number of elapsed cycles since go was raised and
// saturates at TIMEOUT, so a long stall cannot wrap it back to zero.
module gcd_timeout_ctr #(
  parameter int TIMEOUT = 1023,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CW'(TIMEOUT))) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Look one count ahead so the registered abort lands exactly TIMEOUT
  // cycles after go.
  assign hit = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/gcd_job_sequencer.sv
// Initiator side of the GCD core go/done handshake.
// Accepts operand pairs upstream (in_valid/in_ready), issues each pair to the
// core with a one-cycle gcd_go, waits for gcd_done and returns the result
// downstream (out_valid/out_ready). Zero operands bypass the core; a core
// that never answers is aborted after TIMEOUT cycles with a gcd_rst pulse.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid, in_ready, in_a/b    upstream operand pair
//   out_valid, out_ready          downstream result handshake
//   out_gcd, out_err              result payload (err: timeout or 0/0)
//   gcd_go, gcd_a/b, gcd_rst      core controls and operands
//   gcd_done, gcd_result          core completion
//   jobs_done                     results accepted downstream (wraps)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a pair; zero operands resolved here
// ISSUE | gcd_go high for this single cycle
// WAIT  | waiting for gcd_done, watchdog running
// RESP  | result presented until out_ready
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int W       = GCD_W,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_gcd,
  output logic             out_err,
  output logic             gcd_go,
  output logic [W-1:0]     gcd_a,
  output logic [W-1:0]     gcd_b,
  output logic             gcd_rst,
  input  logic             gcd_done,
  input  logic [W-1:0]     gcd_result,
  output logic [CNT_W-1:0] jobs_done
);

  seq_state_e       state, state_next;
  logic [W-1:0]     a_next, b_next, gcd_next;
  logic             err_next, abort_next;
  logic [CNT_W-1:0] jobs_next;
  logic             to_hit;
  logic             to_run;

  assign to_run = (state == ISSUE) || (state == WAIT);

  gcd_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!to_run),
    .enable (to_run),
    .hit    (to_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    a_next     = gcd_a;
    b_next     = gcd_b;
    gcd_next   = out_gcd;
    err_next   = out_err;
    abort_next = 1'b0;
    jobs_next  = jobs_done;
    case (state)
      IDLE: begin
        if (in_valid) begin
          a_next = in_a;
          b_next = in_b;
          if ((in_a == '0) && (in_b == '0)) begin
            gcd_next   = '0;
            err_next   = 1'b1;
            state_next = RESP;
          end else if (in_a == '0) begin
            gcd_next   = in_b;
            err_next   = 1'b0;
            state_next = RESP;
          end else if (in_b == '0) begin
            gcd_next   = in_a;
            err_next   = 1'b0;
            state_next = RESP;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        // done wins over a coincident timeout
        if (gcd_done) begin
          gcd_next   = gcd_result;
          err_next   = 1'b0;
          state_next = RESP;
        end else if (to_hit) begin
          gcd_next   = '0;
          err_next   = 1'b1;
          abort_next = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (out_ready) begin
          jobs_next  = jobs_done + 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake flags are registered from the next state so they line up with
  // the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      gcd_go    <= 1'b0;
      gcd_rst   <= 1'b0;
      out_gcd   <= '0;
      out_err   <= 1'b0;
      gcd_a     <= '0;
      gcd_b     <= '0;
      jobs_done <= '0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == RESP);
      gcd_go    <= (state_next == ISSUE);
      gcd_rst   <= abort_next;
      out_gcd   <= gcd_next;
      out_err   <= err_next;
      gcd_a     <= a_next;
      gcd_b     <= b_next;
      jobs_done <= jobs_next;
    end
  end

endmodule
